// File: rtl/noc_input_vc_requester_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : noc_input_vc_requester_if                                |
// | Description : Bundle between the VC buffers of one router input port,  |
// |               the per-VC requester and the port/VC allocators.         |
// |               Layout of the 2-D fields is [port][vc].                  |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
interface noc_input_vc_requester_if #(
   parameter int CHANNELS = 2,
   parameter int PORTS    = 5
);
   logic [CHANNELS-1:0]                vc_valid;
   logic [CHANNELS-1:0]                vc_head;
   logic [CHANNELS-1:0]                vc_tail;
   logic [CHANNELS-1:0][2:0]           vc_dest;
   logic [CHANNELS-1:0]                vc_pop;
   logic [PORTS-1:0][CHANNELS-1:0]     start_of_packet;
   logic [PORTS-1:0][CHANNELS-1:0]     request;
   logic [PORTS-1:0][CHANNELS-1:0]     grant;
   logic [PORTS-1:0][CHANNELS-1:0]     free;
   logic [PORTS-1:0][CHANNELS-1:0]     end_of_packet;
   logic [CHANNELS-1:0]                err_o;

   // Requester side: consumes buffer status and grants, drives requests.
   modport master (
      input  vc_valid, vc_head, vc_tail, vc_dest, grant,
      output vc_pop, start_of_packet, request, free, end_of_packet, err_o
   );

   // Environment side: buffers and allocators.
   modport slave (
      output vc_valid, vc_head, vc_tail, vc_dest, grant,
      input  vc_pop, start_of_packet, request, free, end_of_packet, err_o
   );
endinterface
`default_nettype wire

// File: rtl/noc_input_vc_requester.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : noc_input_vc_requester                                   |
// | Description : Per-VC packet requester for one router input port.      |
// |               Each VC runs an IDLE/HEAD/BODY FSM that latches the      |
// |               routed output port, raises port/VC requests and pops     |
// |               flits on grant. Malformed traffic sets a sticky error.   |
// |               Optional macro NOC_REQ_STALL_CNT_EN adds per-VC           |
// |               saturating stall counters (stall_cnt output).            |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module noc_input_vc_requester #(
   parameter int CHANNELS = 2,
   parameter int PORTS    = 5
) (
   input  wire logic                   noc_clk,
   input  wire logic                   noc_rst_n,
`ifdef NOC_REQ_STALL_CNT_EN
   output logic [CHANNELS-1:0][15:0]   stall_cnt,
`endif
   noc_input_vc_requester_if.master    bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HEAD = 2'd1,
      BODY = 2'd2
   } state_t;

   // Blocks head acceptance for the first cycle after reset release so the
   // earliest start_of_packet follows the second rising edge.
   logic                armed;
   logic [CHANNELS-1:0] req_v;
   logic [CHANNELS-1:0] sop_v;
   logic [CHANNELS-1:0] pop_v;
   logic [CHANNELS-1:0] tail_v;
   logic [CHANNELS-1:0] err_v;
   logic [2:0]          port_v [CHANNELS];

   // Arm the head-acceptance path one cycle after reset release.
   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) armed <= 1'b0;
      else            armed <= 1'b1;
   end

   for (genvar v = 0; v < CHANNELS; v++) begin : g_vc
      state_t     state, state_nxt;
      logic [2:0] port, port_nxt;
      logic       err, err_nxt;
      logic       gnt_sel;
      logic       req;
      logic       xfer;
      logic       discard;

      // Only a grant on the latched port counts; others are ignored.
      always_comb begin
         gnt_sel = 1'b0;
         for (int p = 0; p < PORTS; p++) begin
            if (int'(port) == p) gnt_sel = bus.grant[p][v];
         end
      end

      assign req  = (state != IDLE) && bus.vc_valid[v];
      assign xfer = req && gnt_sel;

      // Next-state, port latch and error detection.
      always_comb begin
         state_nxt = state;
         port_nxt  = port;
         err_nxt   = err;
         discard   = 1'b0;
         case (state)
            IDLE: begin
               if (armed && bus.vc_valid[v]) begin
                  if (bus.vc_head[v] && (int'(bus.vc_dest[v]) < PORTS)) begin
                     port_nxt  = bus.vc_dest[v];
                     state_nxt = HEAD;
                  end else begin
                     // Stray body flit or unroutable head: drop it.
                     discard = 1'b1;
                     err_nxt = 1'b1;
                  end
               end
            end
            HEAD: begin
               if (xfer) state_nxt = bus.vc_tail[v] ? IDLE : BODY;
            end
            BODY: begin
               if (xfer) begin
                  // A head inside a packet is forwarded as body but flagged.
                  if (bus.vc_head[v]) err_nxt = 1'b1;
                  if (bus.vc_tail[v]) state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end

      // FSM state, latched port and sticky error registers.
      always_ff @(posedge noc_clk or negedge noc_rst_n) begin
         if (!noc_rst_n) begin
            state <= IDLE;
            port  <= 3'd0;
            err   <= 1'b0;
         end else begin
            state <= state_nxt;
            port  <= port_nxt;
            err   <= err_nxt;
         end
      end

      assign req_v[v]  = req;
      assign sop_v[v]  = (state == HEAD);
      assign pop_v[v]  = xfer || discard;
      assign tail_v[v] = xfer && bus.vc_tail[v];
      assign err_v[v]  = err;
      assign port_v[v] = port;

`ifdef NOC_REQ_STALL_CNT_EN
      logic [15:0] stall;

      // Saturating count of cycles spent requesting without a grant.
      always_ff @(posedge noc_clk or negedge noc_rst_n) begin
         if (!noc_rst_n) begin
            stall <= 16'd0;
         end else if (tail_v[v]) begin
            stall <= 16'd0;
         end else if (req && !gnt_sel && (stall != 16'hFFFF)) begin
            stall <= stall + 16'd1;
         end
      end

      assign stall_cnt[v] = stall;
`endif
   end

   // Steer each VC's request/release bits onto its latched port only.
   always_comb begin
      bus.start_of_packet = '0;
      bus.request         = '0;
      bus.free            = '0;
      bus.end_of_packet   = '0;
      for (int p = 0; p < PORTS; p++) begin
         for (int v = 0; v < CHANNELS; v++) begin
            if (int'(port_v[v]) == p) begin
               bus.start_of_packet[p][v] = sop_v[v];
               bus.request[p][v]         = req_v[v];
               bus.free[p][v]            = tail_v[v];
               bus.end_of_packet[p][v]   = tail_v[v];
            end
         end
      end
   end

   assign bus.vc_pop = pop_v;
   assign bus.err_o  = err_v;

endmodule
`default_nettype wire
